// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the MEM stage controller and a variable-latency data memory.
// The controller drives the request side; the memory answers with ack and read data.
interface mem_stage_ctrl_if #(
    parameter int WORD_LEN   = 32,
    parameter int MEM_ADDR_W = 16
);
    logic                  mem_req;
    logic                  mem_we;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [WORD_LEN-1:0]   mem_wdata;
    logic                  mem_ack;
    logic [WORD_LEN-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MIPS MEM stage: issues loads/stores over a req/ack memory bus, freezes the upstream
// pipeline for the duration of the access and feeds a bubble into MEM->WB meanwhile.
module mem_stage_ctrl #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int MEM_ADDR_W   = 16,
    parameter int ADDR_BASE    = 1024,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    WB_EN_IN,
    input  logic                    MEM_R_EN_IN,
    input  logic                    MEM_W_EN_IN,
    input  logic                    MUL_EN_IN,
    input  logic                    COMP_EN_IN,
    input  logic [WORD_LEN-1:0]     ALUResIn,
    input  logic [WORD_LEN-1:0]     stValIn,
    input  logic [WORD_LEN-1:0]     HIGH_IN,
    input  logic [REG_ADDR_LEN-1:0] destIn,
    mem_stage_ctrl_if.master        mem,
    output logic                    freeze,
    output logic                    WB_EN,
    output logic                    MEM_R_EN,
    output logic                    MUL_EN_OUT,
    output logic                    COMP_EN_OUT,
    output logic [WORD_LEN-1:0]     ALURes,
    output logic [WORD_LEN-1:0]     memReadVal,
    output logic [WORD_LEN-1:0]     HIGH_OUT,
    output logic [REG_ADDR_LEN-1:0] dest,
    output logic                    mem_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e                state_q, state_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_LEN-1:0]   wdata_q, wdata_d;
    logic [WORD_LEN-1:0]   rdata_q, rdata_d;
    logic                  we_q, we_d;
    logic                  abort_q, abort_d;
    logic                  err_q, err_d;
    logic [7:0]            cnt_q, cnt_d;

    logic                  memOp;
    logic                  aligned;
    logic                  misLoad;
    logic                  timedOut;
    logic [WORD_LEN-1:0]   offset;

    assign memOp    = MEM_R_EN_IN | MEM_W_EN_IN;
    assign aligned  = (ALUResIn[1:0] == 2'b00);
    assign misLoad  = MEM_R_EN_IN & ~aligned;
    assign offset   = ALUResIn - WORD_LEN'(ADDR_BASE);
    // cnt_q holds the number of ACCESS cycles already elapsed, so this fires on the last allowed one
    assign timedOut = (state_q == ACCESS) && !mem.mem_ack && (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            abort_q <= abort_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        abort_d = abort_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (memOp && aligned) begin
                    addr_d  = MEM_ADDR_W'(offset >> 2);
                    wdata_d = stValIn;
                    we_d    = MEM_W_EN_IN;
                    abort_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end else if (memOp) begin
                    err_d = 1'b1;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                if (mem.mem_ack) begin
                    rdata_d = we_q ? '0 : mem.mem_rdata;
                    state_d = DONE;
                end else if (timedOut) begin
                    rdata_d = '0;
                    abort_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control fields toward MEM->WB are zeroed whenever the pipeline is frozen
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        freeze        = 1'b0;
        WB_EN         = 1'b0;
        MEM_R_EN      = 1'b0;
        MUL_EN_OUT    = 1'b0;
        COMP_EN_OUT   = 1'b0;
        ALURes        = '0;
        memReadVal    = '0;
        HIGH_OUT      = '0;
        dest          = '0;
        mem_err       = 1'b0;
        if (!rst) begin
            mem.mem_req   = (state_q == ACCESS);
            mem.mem_we    = we_q & (state_q == ACCESS);
            mem.mem_addr  = addr_q;
            mem.mem_wdata = wdata_q;
            mem_err       = err_q;
            ALURes        = ALUResIn;
            HIGH_OUT      = HIGH_IN;
            dest          = destIn;
            case (state_q)
                IDLE: begin
                    if (memOp && aligned) begin
                        freeze = 1'b1;
                    end else begin
                        WB_EN       = WB_EN_IN & ~misLoad;
                        MEM_R_EN    = MEM_R_EN_IN & aligned;
                        MUL_EN_OUT  = MUL_EN_IN;
                        COMP_EN_OUT = COMP_EN_IN;
                    end
                end
                ACCESS: freeze = 1'b1;
                DONE: begin
                    WB_EN       = WB_EN_IN & ~(abort_q & ~we_q);
                    MEM_R_EN    = MEM_R_EN_IN;
                    MUL_EN_OUT  = MUL_EN_IN;
                    COMP_EN_OUT = COMP_EN_IN;
                    memReadVal  = rdata_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected MEM->WB results are queued when an
// instruction is presented and compared when it leaves the stage (freeze low).
module tb_mem_stage_ctrl;

    localparam int TIMEOUT = 255;
    localparam int MAX_CYC = 300;

    typedef struct {
        logic        wbEn, memREn, mulEn, compEn, checkRead, isAccess, isStore;
        logic [31:0] aluRes, readVal, high, addr, wdata;
        logic [4:0]  dest;
        int          freezeCycles, reqCycles, errPulses;
    } expect_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbEnIn, memREnIn, memWEnIn, mulEnIn, compEnIn;
    logic [31:0] aluResIn, stValIn, highIn;
    logic [4:0]  destIn;
    logic        freeze, wbEn, memREn, mulEnOut, compEnOut, memErr;
    logic [31:0] aluRes, memReadVal, highOut;
    logic [4:0]  dest;

    expect_t     sbQueue[$];
    int          checkCount = 0;
    int          passCount  = 0;

    mem_stage_ctrl_if #(.WORD_LEN(32), .MEM_ADDR_W(16)) memBus ();

    mem_stage_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .WB_EN_IN    (wbEnIn),
        .MEM_R_EN_IN (memREnIn),
        .MEM_W_EN_IN (memWEnIn),
        .MUL_EN_IN   (mulEnIn),
        .COMP_EN_IN  (compEnIn),
        .ALUResIn    (aluResIn),
        .stValIn     (stValIn),
        .HIGH_IN     (highIn),
        .destIn      (destIn),
        .mem         (memBus),
        .freeze      (freeze),
        .WB_EN       (wbEn),
        .MEM_R_EN    (memREn),
        .MUL_EN_OUT  (mulEnOut),
        .COMP_EN_OUT (compEnOut),
        .ALURes      (aluRes),
        .memReadVal  (memReadVal),
        .HIGH_OUT    (highOut),
        .dest        (dest),
        .mem_err     (memErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic driveNop();
        wbEnIn   = 1'b0;
        memREnIn = 1'b0;
        memWEnIn = 1'b0;
        mulEnIn  = 1'b0;
        compEnIn = 1'b0;
        aluResIn = '0;
        stValIn  = '0;
        highIn   = '0;
        destIn   = '0;
    endtask

    // Presents one instruction, plays the memory (ack on request cycle ackCycle, 0 = never),
    // and compares everything observed against the queued expectation.
    task automatic applyStimulus(input string name, input logic wbIn, rIn, wIn, mulIn, compIn,
                                 input logic [31:0] alu, st, hi, input logic [4:0] d,
                                 input int ackCycle, input logic [31:0] rdataVal);
        expect_t     e, got;
        logic [31:0] off, obsAddr, obsWdata;
        logic        memOp, aligned, aborted, obsWe, done;
        int          reqCycles, freezeCycles, errPulses, bubbleBad, unstable;

        @(posedge clk); #1;
        wbEnIn = wbIn; memREnIn = rIn; memWEnIn = wIn; mulEnIn = mulIn; compEnIn = compIn;
        aluResIn = alu; stValIn = st; highIn = hi; destIn = d;

        memOp          = rIn | wIn;
        aligned        = (alu[1:0] == 2'b00);
        e.isAccess     = memOp && aligned;
        e.isStore      = wIn;
        aborted        = e.isAccess && (ackCycle < 1 || ackCycle > TIMEOUT);
        e.reqCycles    = !e.isAccess ? 0 : (aborted ? TIMEOUT : ackCycle);
        e.freezeCycles = e.isAccess ? e.reqCycles + 1 : 0;
        e.errPulses    = ((memOp && !aligned) || aborted) ? 1 : 0;
        e.wbEn         = wbIn && !(rIn && !aligned) && !(rIn && aborted);
        e.memREn       = rIn && aligned;
        e.mulEn        = mulIn;
        e.compEn       = compIn;
        e.aluRes       = alu;
        e.high         = hi;
        e.dest         = d;
        e.checkRead    = !wIn;
        e.readVal      = (e.isAccess && rIn && !aborted) ? rdataVal : 32'h0;
        off            = alu - 32'd1024;
        e.addr         = {16'h0, off[17:2]};
        e.wdata        = st;
        sbQueue.push_back(e);

        reqCycles = 0; freezeCycles = 0; errPulses = 0; bubbleBad = 0; unstable = 0;
        obsAddr = '0; obsWdata = '0; obsWe = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < MAX_CYC && !done; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            memBus.mem_ack   = 1'b0;
            memBus.mem_rdata = $urandom;
            if (memBus.mem_req) begin
                reqCycles++;
                if (reqCycles == 1) begin
                    obsAddr  = {16'h0, memBus.mem_addr};
                    obsWdata = memBus.mem_wdata;
                    obsWe    = memBus.mem_we;
                end else if ({16'h0, memBus.mem_addr} != obsAddr || memBus.mem_wdata != obsWdata
                             || memBus.mem_we != obsWe) begin
                    unstable++;
                end
                if (reqCycles == ackCycle) begin
                    memBus.mem_ack   = 1'b1;
                    memBus.mem_rdata = rdataVal;
                end
            end
            #4;
            if (memErr) errPulses++;
            if (freeze) begin
                freezeCycles++;
                if (wbEn | memREn | mulEnOut | compEnOut) bubbleBad++;
            end else begin
                done = 1'b1;
                if (sbQueue.size() == 0) begin
                    checkOutput({name, ".sbEmpty"}, 32'd1, 32'd0);
                end else begin
                    got = sbQueue.pop_front();
                    checkOutput({name, ".WB_EN"}, {31'h0, wbEn}, {31'h0, got.wbEn});
                    checkOutput({name, ".MEM_R_EN"}, {31'h0, memREn}, {31'h0, got.memREn});
                    checkOutput({name, ".MUL_EN"}, {31'h0, mulEnOut}, {31'h0, got.mulEn});
                    checkOutput({name, ".COMP_EN"}, {31'h0, compEnOut}, {31'h0, got.compEn});
                    checkOutput({name, ".ALURes"}, aluRes, got.aluRes);
                    checkOutput({name, ".HIGH"}, highOut, got.high);
                    checkOutput({name, ".dest"}, {27'h0, dest}, {27'h0, got.dest});
                    if (got.checkRead) checkOutput({name, ".memReadVal"}, memReadVal, got.readVal);
                end
            end
        end
        if (!done) begin
            checkOutput({name, ".leaveTimeout"}, 32'd1, 32'd0);
            if (sbQueue.size() != 0) void'(sbQueue.pop_front());
        end

        // One idle cycle afterwards catches the misaligned error pulse and any stray request
        @(posedge clk); #1;
        driveNop();
        memBus.mem_ack = 1'b0;
        #4;
        if (memErr) errPulses++;
        checkOutput({name, ".reqAfter"}, {31'h0, memBus.mem_req}, 32'd0);
        checkOutput({name, ".errPulses"}, errPulses, e.errPulses);
        checkOutput({name, ".freezeCycles"}, freezeCycles, e.freezeCycles);
        checkOutput({name, ".reqCycles"}, reqCycles, e.reqCycles);
        checkOutput({name, ".bubble"}, bubbleBad, 32'd0);
        if (e.isAccess) begin
            checkOutput({name, ".mem_addr"}, obsAddr, e.addr);
            checkOutput({name, ".mem_we"}, {31'h0, obsWe}, {31'h0, e.isStore});
            checkOutput({name, ".busStable"}, unstable, 32'd0);
            if (e.isStore) checkOutput({name, ".mem_wdata"}, obsWdata, e.wdata);
        end
    endtask

    initial begin
        logic [31:0] randAddr;
        logic        isStore;
        int          seen;

        rst = 1'b1;
        driveNop();
        memBus.mem_ack   = 1'b0;
        memBus.mem_rdata = '0;
        wbEnIn   = 1'b1;
        aluResIn = 32'h55;
        destIn   = 5'd3;
        @(posedge clk); #1;
        @(posedge clk); #5;
        checkOutput("rst.freeze", {31'h0, freeze}, 32'd0);
        checkOutput("rst.mem_req", {31'h0, memBus.mem_req}, 32'd0);
        checkOutput("rst.WB_EN", {31'h0, wbEn}, 32'd0);
        checkOutput("rst.ALURes", aluRes, 32'd0);
        checkOutput("rst.mem_err", {31'h0, memErr}, 32'd0);
        rst = 1'b0;
        driveNop();

        applyStimulus("aluOp",     1, 0, 0, 0, 0, 32'h55, 32'h0, 32'h0, 5'd3, 0, 32'h0);
        applyStimulus("loadFast",  1, 1, 0, 0, 0, 32'd1032, 32'h0, 32'h0, 5'd5, 1, 32'hDEADBEEF);
        applyStimulus("storeSlow", 0, 0, 1, 0, 0, 32'd1024, 32'h1234, 32'h0, 5'd0, 5, 32'h0);
        applyStimulus("loadMis",   1, 1, 0, 0, 0, 32'd1026, 32'h0, 32'h0, 5'd7, 1, 32'h0);
        applyStimulus("mulComp",   1, 0, 0, 1, 1, 32'hCAFE0001, 32'h0, 32'h00AB00CD, 5'd9, 0, 32'h0);
        applyStimulus("loadMid",   1, 1, 0, 0, 1, 32'd1424, 32'h0, 32'h0, 5'd11, 3, 32'h0BADF00D);
        applyStimulus("storeMis",  0, 0, 1, 0, 0, 32'd1027, 32'h9999, 32'h0, 5'd0, 1, 32'h0);
        applyStimulus("loadWrap",  1, 1, 0, 0, 0, 32'd0, 32'h0, 32'h0, 5'd12, 2, 32'h13572468);
        applyStimulus("loadAbort", 1, 1, 0, 0, 0, 32'd1036, 32'h0, 32'h0, 5'd13, 0, 32'h0);
        applyStimulus("loadResume",1, 1, 0, 0, 0, 32'd1040, 32'h0, 32'h0, 5'd14, 2, 32'h2468ACE0);

        for (int i = 0; i < 6; i++) begin
            isStore  = i[0];
            randAddr = 32'd1024 + ($urandom_range(0, 4095) << 2);
            applyStimulus("rand", !isStore, !isStore, isStore, 0, 0, randAddr, $urandom, 32'h0,
                          5'($urandom_range(1, 31)), $urandom_range(1, 6), $urandom);
        end

        // Reset in the middle of an access must abandon it silently
        @(posedge clk); #1;
        wbEnIn = 1'b1; memREnIn = 1'b1; aluResIn = 32'd1044; destIn = 5'd15;
        memBus.mem_ack = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 10 && seen < 2; cyc++) begin
            @(posedge clk); #1;
            if (memBus.mem_req) seen++;
        end
        checkOutput("rstAcc.reqSeen", seen, 32'd2);
        rst = 1'b1;
        #4;
        checkOutput("rstAcc.reqDuringRst", {31'h0, memBus.mem_req}, 32'd0);
        checkOutput("rstAcc.freezeDuringRst", {31'h0, freeze}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        driveNop();
        memBus.mem_ack   = 1'b1;
        memBus.mem_rdata = 32'hBAD0BAD0;
        #4;
        checkOutput("rstAcc.reqAfter", {31'h0, memBus.mem_req}, 32'd0);
        checkOutput("rstAcc.freezeAfter", {31'h0, freeze}, 32'd0);
        checkOutput("rstAcc.errAfter", {31'h0, memErr}, 32'd0);
        @(posedge clk); #1;
        memBus.mem_ack = 1'b0;
        #4;
        checkOutput("rstAcc.errLater", {31'h0, memErr}, 32'd0);
        checkOutput("rstAcc.memReadVal", memReadVal, 32'd0);

        applyStimulus("loadPostRst", 1, 1, 0, 0, 0, 32'd1048, 32'h0, 32'h0, 5'd16, 1, 32'h600DCAFE);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
